// File: rtl/pipelined_add_sub.sv
// Pipelined integer add/subtract unit. The operation is split into STAGES
// carry-chained slices, with valid/ready flow control and carry/overflow/zero flags.
// Optional: define PIPELINED_ADD_SUB_SAT_EN to saturate results on signed overflow.
module pipelined_add_sub #(
    parameter int unsigned WIDTH  = 32,
    parameter int unsigned STAGES = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_a,
    input  logic [WIDTH-1:0] in_b,
    input  logic             in_sub,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_sum,
    output logic             out_carry,
    output logic             out_overflow,
    output logic             out_zero
);

    localparam int unsigned SLICE = WIDTH / STAGES;
    localparam int unsigned LAST  = STAGES - 1;

`ifdef PIPELINED_ADD_SUB_SAT_EN
    localparam logic [WIDTH-1:0] SAT_POS = {1'b0, {(WIDTH-1){1'b1}}};
    localparam logic [WIDTH-1:0] SAT_NEG = {1'b1, {(WIDTH-1){1'b0}}};
`endif

    // Per-stage registers: valid, operands (A, B'), partial sum and slice carry
    logic [STAGES-1:0] v_q;
    logic [STAGES-1:0] c_q;
    logic [WIDTH-1:0]  a_q [STAGES];
    logic [WIDTH-1:0]  b_q [STAGES];
    logic [WIDTH-1:0]  s_q [STAGES];
    logic              ovf_q;
    logic              zero_q;

    // Combinational stage inputs and next-state values
    logic [STAGES:0]   adv;
    logic [STAGES-1:0] src_v;
    logic [STAGES-1:0] src_c;
    logic [STAGES-1:0] c_d;
    logic [WIDTH-1:0]  src_a [STAGES];
    logic [WIDTH-1:0]  src_b [STAGES];
    logic [WIDTH-1:0]  src_s [STAGES];
    logic [WIDTH-1:0]  s_d   [STAGES];
    logic [SLICE:0]    part;
    logic [WIDTH-1:0]  res_d;
    logic              ovf_d;
    logic              zero_d;

    // Advance chain: a stage loads when empty or when its successor advances
    always_comb begin
        adv          = '0;
        src_v        = '0;
        adv[STAGES]  = out_ready;
        for (int k = STAGES - 1; k >= 0; k--) begin
            adv[k] = !v_q[k] || adv[k+1];
        end
        src_v[0] = in_valid;
        for (int k = 1; k < STAGES; k++) begin
            src_v[k] = v_q[k-1];
        end
    end

    assign in_ready = adv[0];

    // Slice adders, final-stage flags and optional saturation
    always_comb begin
        src_c = '0;
        c_d   = '0;
        part  = '0;
        for (int k = 0; k < STAGES; k++) begin
            src_a[k] = '0;
            src_b[k] = '0;
            src_s[k] = '0;
            s_d[k]   = '0;
        end
        src_a[0] = in_a;
        src_b[0] = in_sub ? ~in_b : in_b;
        src_c[0] = in_sub;
        for (int k = 1; k < STAGES; k++) begin
            src_a[k] = a_q[k-1];
            src_b[k] = b_q[k-1];
            src_s[k] = s_q[k-1];
            src_c[k] = c_q[k-1];
        end
        for (int k = 0; k < STAGES; k++) begin
            part = {1'b0, src_a[k][k*SLICE +: SLICE]}
                 + {1'b0, src_b[k][k*SLICE +: SLICE]}
                 + (SLICE+1)'(src_c[k]);
            s_d[k] = src_s[k];
            s_d[k][k*SLICE +: SLICE] = part[SLICE-1:0];
            c_d[k] = part[SLICE];
        end
        ovf_d = (src_a[LAST][WIDTH-1] == src_b[LAST][WIDTH-1]) &&
                (s_d[LAST][WIDTH-1] != src_a[LAST][WIDTH-1]);
`ifdef PIPELINED_ADD_SUB_SAT_EN
        if (ovf_d) begin
            res_d = src_a[LAST][WIDTH-1] ? SAT_NEG : SAT_POS;
        end else begin
            res_d = s_d[LAST];
        end
`else
        res_d = s_d[LAST];
`endif
        zero_d       = (res_d == '0);
        s_d[LAST]    = res_d;
    end

    // Stage registers; data only loads when a valid beat moves in
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            v_q    <= '0;
            c_q    <= '0;
            ovf_q  <= 1'b0;
            zero_q <= 1'b0;
            for (int k = 0; k < STAGES; k++) begin
                a_q[k] <= '0;
                b_q[k] <= '0;
                s_q[k] <= '0;
            end
        end else begin
            for (int k = 0; k < STAGES; k++) begin
                if (adv[k]) begin
                    v_q[k] <= src_v[k];
                    if (src_v[k]) begin
                        a_q[k] <= src_a[k];
                        b_q[k] <= src_b[k];
                        s_q[k] <= s_d[k];
                        c_q[k] <= c_d[k];
                    end
                end
            end
            if (adv[LAST] && src_v[LAST]) begin
                ovf_q  <= ovf_d;
                zero_q <= zero_d;
            end
        end
    end

    assign out_valid    = v_q[LAST];
    assign out_sum      = s_q[LAST];
    assign out_carry    = c_q[LAST];
    assign out_overflow = ovf_q;
    assign out_zero     = zero_q;

endmodule

// File: tb/tb_pipelined_add_sub.sv
// Scoreboard bench for pipelined_add_sub (WIDTH=32, STAGES=4), directed vectors.
module tb_pipelined_add_sub;

    localparam int unsigned WIDTH  = 32;
    localparam int unsigned STAGES = 4;

    logic             clk = 1'b0;
    logic             rst_n;
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] in_a;
    logic [WIDTH-1:0] in_b;
    logic             in_sub;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] out_sum;
    logic             out_carry;
    logic             out_overflow;
    logic             out_zero;

    int checks = 0;
    int errors = 0;
    int nacc   = 0;
    logic [34:0] exp_q [$];

    pipelined_add_sub #(.WIDTH(WIDTH), .STAGES(STAGES)) dut (
        .clk(clk), .rst_n(rst_n),
        .in_valid(in_valid), .in_ready(in_ready),
        .in_a(in_a), .in_b(in_b), .in_sub(in_sub),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_sum(out_sum), .out_carry(out_carry),
        .out_overflow(out_overflow), .out_zero(out_zero)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    // Present a beat (call just after a rising edge); returns just after the accepting edge
    task automatic send(input logic [31:0] a, input logic [31:0] b, input logic sub,
                        input logic [31:0] e_sum, input logic e_c, input logic e_v,
                        input logic e_z);
        bit done = 0;
        in_valid = 1'b1; in_a = a; in_b = b; in_sub = sub;
        for (int t = 0; t < 50 && !done; t++) begin
            @(negedge clk);
            if (in_ready) begin
                exp_q.push_back({e_c, e_v, e_z, e_sum});
                nacc++;
                done = 1;
            end
            @(posedge clk); #1;
        end
        if (!done) chk("accept_timeout", 64'd0, 64'd1);
        in_valid = 1'b0;
    endtask

    // Monitor: every transfer at the output is popped and compared
    always @(negedge clk) begin
        if (rst_n && out_valid && out_ready) begin
            if (exp_q.size() == 0) begin
                chk("unexpected_output", {29'd0, out_carry, out_overflow, out_zero, out_sum}, 64'd0);
            end else begin
                chk("result", {29'd0, out_carry, out_overflow, out_zero, out_sum},
                    {29'd0, exp_q.pop_front()});
            end
        end
    end

    initial begin
        int n0;
        bit seen;
        rst_n = 1'b0; in_valid = 1'b0; in_a = '0; in_b = '0; in_sub = 1'b0; out_ready = 1'b1;

        // Reset: inputs toggle, outputs stay cleared
        for (int i = 0; i < 4; i++) begin
            @(posedge clk); #1;
            in_valid = ~in_valid; in_a = $urandom; in_b = $urandom; in_sub = ~in_sub;
        end
        @(negedge clk);
        chk("rst_valid", 64'(out_valid), 64'd0);
        chk("rst_sum", 64'(out_sum), 64'd0);
        chk("rst_flags", 64'({out_carry, out_overflow, out_zero}), 64'd0);
        chk("rst_in_ready", 64'(in_ready), 64'd1);
        in_valid = 1'b0; in_sub = 1'b0;
        @(posedge clk); #1;
        rst_n = 1'b1;
        @(posedge clk); #1;

        // Latency and back-to-back throughput
        send(32'd2, 32'd20, 1'b0, 32'd22, 1'b0, 1'b0, 1'b0);
        send(32'd25, 32'd5, 1'b0, 32'd30, 1'b0, 1'b0, 1'b0);
        @(negedge clk); chk("lat_c2_valid", 64'(out_valid), 64'd0);
        @(negedge clk); chk("lat_c3_valid", 64'(out_valid), 64'd0);
        @(negedge clk); chk("lat_c4_valid", 64'(out_valid), 64'd1);
        chk("lat_c4_sum", 64'(out_sum), 64'd22);
        @(negedge clk); chk("lat_c5_valid", 64'(out_valid), 64'd1);
        chk("lat_c5_sum", 64'(out_sum), 64'd30);
        @(posedge clk); #1;

        // Slice carries, subtract, overflow
        send(32'h0000_FFFF, 32'd1, 1'b0, 32'h0001_0000, 1'b0, 1'b0, 1'b0);
        send(32'hFFFF_FFFF, 32'd1, 1'b0, 32'h0000_0000, 1'b1, 1'b0, 1'b1);
        send(32'd5, 32'd25, 1'b1, 32'hFFFF_FFEC, 1'b0, 1'b0, 1'b0);
        send(32'd25, 32'd5, 1'b1, 32'd20, 1'b1, 1'b0, 1'b0);
        send(32'd7, 32'd7, 1'b1, 32'd0, 1'b1, 1'b0, 1'b1);
`ifdef PIPELINED_ADD_SUB_SAT_EN
        send(32'h7FFF_FFFF, 32'd1, 1'b0, 32'h7FFF_FFFF, 1'b0, 1'b1, 1'b0);
        send(32'h8000_0000, 32'd1, 1'b1, 32'h8000_0000, 1'b1, 1'b1, 1'b0);
        send(32'h8000_0000, 32'h8000_0000, 1'b0, 32'h8000_0000, 1'b1, 1'b1, 1'b0);
`else
        send(32'h7FFF_FFFF, 32'd1, 1'b0, 32'h8000_0000, 1'b0, 1'b1, 1'b0);
        send(32'h8000_0000, 32'd1, 1'b1, 32'h7FFF_FFFF, 1'b1, 1'b1, 1'b0);
        send(32'h8000_0000, 32'h8000_0000, 1'b0, 32'h0000_0000, 1'b1, 1'b1, 1'b1);
`endif
        repeat (8) @(posedge clk); #1;

        // Backpressure with an upstream bubble that must collapse
        out_ready = 1'b0;
        n0 = nacc;
        fork
            begin
                send(32'd1, 32'd100, 1'b0, 32'd101, 1'b0, 1'b0, 1'b0);
                @(posedge clk); #1;
                for (int i = 2; i <= 6; i++)
                    send(32'(i), 32'd100, 1'b0, 32'(100 + i), 1'b0, 1'b0, 1'b0);
            end
        join_none
        repeat (8) @(posedge clk); #1;
        chk("bp_accepts", 64'(nacc - n0), 64'd4);
        chk("bp_in_ready_full", 64'(in_ready), 64'd0);
        out_ready = 1'b1;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            if (i == 0) chk("bp_full_accept", 64'(in_ready), 64'd1);
            chk("bp_valid", 64'(out_valid), 64'd1);
            chk("bp_order", 64'(out_sum), 64'(101 + i));
        end
        wait fork;
        @(posedge clk); #1;

        // Reset with three beats in flight discards them
        out_ready = 1'b0;
        send(32'd1, 32'd1, 1'b0, 32'd2, 1'b0, 1'b0, 1'b0);
        send(32'd2, 32'd2, 1'b0, 32'd4, 1'b0, 1'b0, 1'b0);
        send(32'd3, 32'd3, 1'b0, 32'd6, 1'b0, 1'b0, 1'b0);
        seen = 0;
        for (int t = 0; t < 20 && !seen; t++) begin
            @(negedge clk);
            seen = out_valid;
        end
        chk("mid_valid_before", 64'(seen), 64'd1);
        @(posedge clk); #2;
        rst_n = 1'b0;
        #1;
        chk("mid_async_drop", 64'(out_valid), 64'd0);
        chk("mid_sum_clear", 64'(out_sum), 64'd0);
        exp_q.delete();
        @(posedge clk); #1;
        rst_n = 1'b1;
        out_ready = 1'b1;
        repeat (10) @(posedge clk);
        #1;

        // Drain: everything expected must have appeared
        for (int t = 0; t < 50 && exp_q.size() != 0; t++) @(posedge clk);
        chk("scoreboard_empty", 64'(exp_q.size()), 64'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
